escalar_seq: RTL and testbench
==============================

# escalar_seq

Sequential scalar-times-matrix engine for the coprocessor ALU. It runs a DIM×DIM matrix of signed 8-bit elements through a single shared 8×8 signed multiplier, one element at a time. Each element is read from the coprocessor's element-addressed matrix memory and each result is written back to a destination region. A sticky overflow flag is reported at completion. It trades the 25-multiplier parallel datapath for one multiplier plus an FSM and a memory handshake.

## Interface
- DIM, 5, matrix dimension; legal 1..5; element count E = DIM*DIM
- ADDR_W, 5, memory element address width
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  launch request; sampled only in IDLE
- escalar  input  8  signed scalar; captured on start acceptance
- src_base  input  ADDR_W  address of element 0 of source matrix; captured on start
- dst_base  input  ADDR_W  address of element 0 of result matrix; captured on start
- mem_rd  output  1  read strobe
- mem_wr  output  1  write strobe
- mem_addr  output  ADDR_W  element address for read or write
- mem_rdata  input  8  read data, valid exactly one cycle after mem_rd
- mem_wdata  output  8  write data, valid with mem_wr
- busy  output  1  high in RD, MUL, WR
- done  output  1  one-cycle pulse at completion
- overflow  output  1  sticky: any element overflowed in the current/last run

## Operation
- States: IDLE, RD, MUL, WR, FIN.
- IDLE: if start=1, capture escalar/src_base/dst_base, clear idx and overflow, go to RD. Otherwise stay.
- RD: mem_rd=1, mem_addr=src_base+idx. Go to MUL.
- MUL: register p = signed(mem_rdata) × signed(escalar_reg), 16-bit signed. OR the element overflow bit into overflow. Go to WR.
- WR: mem_wr=1, mem_addr=dst_base+idx, mem_wdata=p[7:0] (see Configuration). If idx==E-1 go to FIN, else idx+1 and go to RD.
- FIN: done=1, busy=0. Go to IDLE.
- Element overflow = p[15:7] not all-equal, i.e. the result does not fit signed 8 bits.
- Address arithmetic is modulo 2^ADDR_W; wrap-around past the top address is legal and not flagged.
- src_base==dst_base (in-place) is legal: each element is read before it is written, and no element is read after its own write.
- start outside IDLE (including in FIN) is ignored; there is no queueing.
- mem_rd and mem_wr are never both high. mem_addr/mem_wdata are don't-care when their strobes are low, but driven to 0.

## Timing
- Reset (rst_n=0 at an edge): state IDLE; busy=0, done=0, overflow=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, idx=0.
- Reset mid-run aborts immediately. The write in flight is dropped if reset hits before its WR cycle, and no done is produced.
- Start accepted at edge k: RD occupies cycle k+1. Each element costs 3 cycles (RD, MUL, WR).
- Last WR is in cycle k+3E; done is high in cycle k+3E+1. For DIM=5 that is done at k+76.
- overflow is updated in MUL cycles and holds its final value from FIN until the next accepted start, which clears it.
- Back-to-back: start high during FIN is ignored; the earliest re-accept is the IDLE cycle after FIN.

## Configuration
- ESCALAR_SAT_EN defined: on element overflow, mem_wdata saturates to 8'h7F if p>0, else 8'h80. The overflow flag is still set.
- ESCALAR_SAT_EN undefined: mem_wdata = p[7:0] (two's-complement wrap). Overflow is flag-only.

## Test plan
- DIM=5, escalar=2, src elements 0..24, src_base=0, dst_base=25 (wrap into 0..17 at ADDR_W=5 with in-range check) → dst[i]=2i on all 25 writes; overflow=0; done exactly at k+76; busy high 75 cycles.
- escalar=8'hFF (−1), element 8'h80 (−128) → p=+128. Without macro: write 8'h80, overflow=1. With ESCALAR_SAT_EN: write 8'h7F, overflow=1.
- escalar=16, elements {8, −8, 7}, DIM=… (E covers them) → 8×16=128 flags overflow; −8×16=−128 does not flag; 7×16=112 does not flag. Overflow stays 1 after done.
- In-place run with src_base=dst_base=3, escalar=3 → each address is written exactly once with 3× its original value; read-before-write ordering is checked per address.
- start pulsed in the middle of a run and during FIN → no restart and no change to captured escalar. A new start in the following IDLE clears overflow and runs normally.
- rst_n=0 in a MUL cycle of element 10 → next cycle all outputs at reset values, no mem_wr for element 10, no done. A subsequent start runs a full E-element pass.

Source files
------------

// File: rtl/escalar_seq.sv
// escalar_seq: DIM x DIM signed matrix times signed scalar, one element per
// RD/MUL/WR pass through a single 8x8 multiplier. Define ESCALAR_SAT_EN to saturate.
module escalar_seq #(
  parameter int DIM    = 5,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        escalar,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int E     = DIM * DIM;
  localparam int IDX_W = (E > 1) ? $clog2(E) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(E - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    MUL,
    WR,
    FIN
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_nxt;
  logic [7:0]          esc_q;
  logic [ADDR_W-1:0]   src_q;
  logic [ADDR_W-1:0]   dst_q;
  logic signed [15:0]  prod;
  logic                elem_ovf;
  logic [7:0]          res;

  assign idx_nxt = idx + IDX_W'(1);

  // element product, 8-bit fit check and the byte to write back
  always_comb begin
    prod     = $signed(mem_rdata) * $signed(esc_q);
    elem_ovf = ~((&prod[15:7]) | ~(|prod[15:7]));
`ifdef ESCALAR_SAT_EN
    if (elem_ovf)
      res = (prod > 16'sd0) ? 8'h7F : 8'h80;
    else
      res = prod[7:0];
`else
    res = prod[7:0];
`endif
  end

  // sequencer: state, index, captured operands and registered memory strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      esc_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            esc_q    <= escalar;
            src_q    <= src_base;
            dst_q    <= dst_base;
            idx      <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            mem_rd   <= 1'b1;
            mem_addr <= src_base;
            state    <= RD;
          end
        end
        RD: begin
          mem_rd   <= 1'b0;
          mem_addr <= '0;
          state    <= MUL;
        end
        MUL: begin
          overflow  <= overflow | elem_ovf;
          mem_wr    <= 1'b1;
          mem_addr  <= dst_q + ADDR_W'(idx);
          mem_wdata <= res;
          state     <= WR;
        end
        WR: begin
          mem_wr    <= 1'b0;
          mem_wdata <= '0;
          if (idx == LAST) begin
            mem_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= FIN;
          end else begin
            idx      <= idx_nxt;
            mem_rd   <= 1'b1;
            mem_addr <= src_q + ADDR_W'(idx_nxt);
            state    <= RD;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_escalar_seq.sv
// tb_escalar_seq: randomized runs of escalar_seq against a sequential
// array model of the scalar-times-matrix pass, plus timing and reset scenarios.
module tb_escalar_seq;

  localparam int DIM = 5;
  localparam int AW  = 5;
  localparam int E   = DIM * DIM;
  localparam int MS  = 1 << AW;
`ifdef ESCALAR_SAT_EN
  localparam logic [7:0] POS128 = 8'h7F;
`else
  localparam logic [7:0] POS128 = 8'h80;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    escalar = '0;
  logic [AW-1:0] src_base = '0;
  logic [AW-1:0] dst_base = '0;
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata = '0;
  logic [7:0]    mem_wdata;
  logic          busy;
  logic          done;
  logic          overflow;

  int            cyc = 0;
  logic [7:0]    mem [MS];
  logic [7:0]    load_data [MS];
  logic          load_req = 1'b0;

  logic [AW-1:0] rd_a [$];
  logic [AW-1:0] wr_a [$];
  logic [7:0]    wr_d [$];
  int            rd_c [$];
  int            wr_c [$];
  int            done_c [$];
  int            busy_n = 0;
  int            both_n = 0;

  int            vectors = 0;
  int            miscompares = 0;
  int            rb, wb, db, bb;

  logic [7:0]    ex_d [E];
  logic [AW-1:0] ex_a [E];
  bit            ex_ovf;

  escalar_seq #(.DIM(DIM), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .escalar  (escalar),
    .src_base (src_base),
    .dst_base (dst_base),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // memory: read data one cycle after mem_rd, junk otherwise
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load_req) mem <= load_data;
    else if (mem_wr) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem_rd ? mem[mem_addr] : 8'($urandom);
  end

  // bus log sampled mid-cycle
  always @(negedge clk) begin
    if (mem_rd) begin
      rd_a.push_back(mem_addr);
      rd_c.push_back(cyc);
    end
    if (mem_wr) begin
      wr_a.push_back(mem_addr);
      wr_d.push_back(mem_wdata);
      wr_c.push_back(cyc);
    end
    if (done) done_c.push_back(cyc);
    if (busy) busy_n++;
    if (mem_rd && mem_wr) both_n++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [7:0] mul_ref(input logic [7:0] x,
                                         input logic [7:0] s,
                                         output bit ovf);
    int p;
    p = int'($signed(x)) * int'($signed(s));
    ovf = (p > 127) || (p < -128);
`ifdef ESCALAR_SAT_EN
    if (ovf) return (p > 0) ? 8'h7F : 8'h80;
`endif
    return 8'(p);
  endfunction

  task automatic build_model(input logic [7:0] s,
                             input logic [AW-1:0] src,
                             input logic [AW-1:0] dst);
    logic [7:0] m [MS];
    logic [AW-1:0] a;
    bit o;
    m = mem;
    ex_ovf = 1'b0;
    for (int i = 0; i < E; i++) begin
      a = src + AW'(i);
      ex_d[i] = mul_ref(m[a], s, o);
      ex_ovf |= o;
      ex_a[i] = dst + AW'(i);
      m[ex_a[i]] = ex_d[i];
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic load_mem;
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    tick;
  endtask

  task automatic snap;
    rb = rd_a.size();
    wb = wr_a.size();
    db = done_c.size();
    bb = busy_n;
  endtask

  task automatic launch(input logic [7:0] s, input logic [AW-1:0] src,
                        input logic [AW-1:0] dst, output int k);
    build_model(s, src, dst);
    snap;
    start = 1'b1;
    escalar = s;
    src_base = src;
    dst_base = dst;
    @(posedge clk);
    #1;
    k = cyc;
    start = 1'b0;
    tick;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * E + 20; i++) begin
      if (done_c.size() > db) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick;
    vectors++;
    if ({busy, done, overflow, mem_rd, mem_wr, mem_addr, mem_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got %b want 0",
               {busy, done, overflow, mem_rd, mem_wr, mem_addr, mem_wdata});
    end
    rst_n = 1'b1;
    repeat (2) tick;
    vectors++;
    if ({busy, done, mem_rd, mem_wr} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_idle got %b want 0000", {busy, done, mem_rd, mem_wr});
    end
  endtask

  task automatic test_basic;
    int k;
    bit ok;
    for (int i = 0; i < MS; i++)
      load_data[i] = (i < E) ? 8'(i) : 8'($urandom);
    load_mem;
    launch(8'd2, 5'd0, 5'd25, k);
    wait_done(ok);
    vectors++;
    if (!ok || done_c[db] !== k + 3 * E) begin
      miscompares++;
      $display("FAIL basic_done_cyc got %0d want %0d",
               ok ? done_c[db] - k : -1, 3 * E);
    end
    vectors++;
    if (done_c.size() - db !== 1 || busy_n - bb !== 3 * E) begin
      miscompares++;
      $display("FAIL basic_busy got %0d/%0d want 1/%0d",
               done_c.size() - db, busy_n - bb, 3 * E);
    end
    vectors++;
    if (wr_a.size() - wb !== E) begin
      miscompares++;
      $display("FAIL basic_wr_count got %0d want %0d", wr_a.size() - wb, E);
    end
    for (int i = 0; i < E; i++) begin
      if (wb + i < wr_a.size() && rb + i < rd_a.size()) begin
        vectors++;
        if (wr_a[wb+i] !== ex_a[i] || wr_d[wb+i] !== ex_d[i] ||
            rd_a[rb+i] !== AW'(i) || wr_c[wb+i] !== k + 3 * i + 2) begin
          miscompares++;
          $display("FAIL basic_el%0d got %h@%h c%0d rd%h want %h@%h c%0d",
                   i, wr_d[wb+i], wr_a[wb+i], wr_c[wb+i] - k, rd_a[rb+i],
                   ex_d[i], ex_a[i], 3 * i + 2);
        end
      end
    end
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_ovf got %b want 0", overflow);
    end
  endtask

  task automatic test_random;
    int k;
    bit ok;
    logic [7:0] s;
    logic [AW-1:0] sa, da;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < MS; i++) load_data[i] = 8'($urandom);
      load_mem;
      s = 8'($urandom);
      sa = AW'($urandom);
      da = AW'($urandom);
      launch(s, sa, da, k);
      wait_done(ok);
      vectors++;
      if (!ok || wr_a.size() - wb !== E) begin
        miscompares++;
        $display("FAIL rand%0d_count got %0d want %0d", r, wr_a.size() - wb, E);
      end
      for (int i = 0; i < E; i++) begin
        if (wb + i < wr_a.size()) begin
          vectors++;
          if (wr_a[wb+i] !== ex_a[i] || wr_d[wb+i] !== ex_d[i]) begin
            miscompares++;
            $display("FAIL rand%0d_el%0d got %h@%h want %h@%h", r, i,
                     wr_d[wb+i], wr_a[wb+i], ex_d[i], ex_a[i]);
          end
        end
      end
      vectors++;
      if (overflow !== ex_ovf) begin
        miscompares++;
        $display("FAIL rand%0d_ovf got %b want %b", r, overflow, ex_ovf);
      end
    end
  endtask

  task automatic test_neg_overflow;
    int k;
    bit ok;
    for (int i = 0; i < MS; i++) load_data[i] = 8'($urandom_range(0, 100));
    load_data[0] = 8'h80;
    load_mem;
    launch(8'hFF, 5'd0, 5'd25, k);
    wait_done(ok);
    vectors++;
    if (!ok || wr_d[wb] !== POS128 || wr_a[wb] !== 5'd25) begin
      miscompares++;
      $display("FAIL neg128_wr got %h@%h want %h@19", wr_d[wb], wr_a[wb], POS128);
    end
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL neg128_ovf got %b want 1", overflow);
    end
  endtask

  task automatic test_boundary;
    int k;
    bit ok;
    logic [7:0] want [3];
    want[0] = POS128;
    want[1] = 8'h80;
    want[2] = 8'h70;
    for (int i = 0; i < MS; i++) load_data[i] = 8'h00;
    load_data[5] = 8'd8;
    load_data[6] = 8'hF8;
    load_data[7] = 8'd7;
    load_mem;
    launch(8'd16, 5'd5, 5'd5, k);
    wait_done(ok);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (!ok || wr_d[wb+i] !== want[i]) begin
        miscompares++;
        $display("FAIL bnd_el%0d got %h want %h", i, wr_d[wb+i], want[i]);
      end
    end
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL bnd_ovf_fin got %b want 1", overflow);
    end
    repeat (3) tick;
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL bnd_ovf_hold got %b want 1", overflow);
    end
    load_data[5] = 8'hF8;
    load_data[6] = 8'd7;
    load_data[7] = 8'h00;
    load_mem;
    launch(8'd16, 5'd5, 5'd5, k);
    wait_done(ok);
    vectors++;
    if (!ok || overflow !== 1'b0 || wr_d[wb] !== 8'h80 || wr_d[wb+1] !== 8'h70) begin
      miscompares++;
      $display("FAIL bnd_noovf got %b %h %h want 0 80 70",
               overflow, wr_d[wb], wr_d[wb+1]);
    end
  endtask

  task automatic test_inplace;
    int k, viol;
    bit ok;
    for (int i = 0; i < MS; i++) load_data[i] = 8'($urandom);
    load_mem;
    launch(8'd3, 5'd3, 5'd3, k);
    wait_done(ok);
    vectors++;
    if (!ok || wr_a.size() - wb !== E) begin
      miscompares++;
      $display("FAIL inpl_count got %0d want %0d", wr_a.size() - wb, E);
    end
    for (int i = 0; i < E; i++) begin
      if (wb + i < wr_a.size()) begin
        vectors++;
        if (wr_a[wb+i] !== ex_a[i] || wr_d[wb+i] !== ex_d[i]) begin
          miscompares++;
          $display("FAIL inpl_el%0d got %h@%h want %h@%h", i,
                   wr_d[wb+i], wr_a[wb+i], ex_d[i], ex_a[i]);
        end
      end
    end
    viol = 0;
    for (int w = wb; w < wr_a.size(); w++) begin
      for (int r = rb; r < rd_a.size(); r++)
        if (rd_a[r] == wr_a[w] && rd_c[r] > wr_c[w]) viol++;
      for (int w2 = w + 1; w2 < wr_a.size(); w2++)
        if (wr_a[w2] == wr_a[w]) viol++;
    end
    vectors++;
    if (viol !== 0) begin
      miscompares++;
      $display("FAIL inpl_order got %0d violations want 0", viol);
    end
  endtask

  task automatic test_back_to_back;
    int k1, k2, d;
    bit ok;
    for (int i = 0; i < MS; i++) load_data[i] = 8'($urandom);
    load_data[4] = 8'd100;
    load_mem;
    launch(8'd100, 5'd4, 5'd4, k1);
    repeat (30) tick;
    start = 1'b1;
    escalar = 8'd1;
    src_base = 5'd9;
    dst_base = 5'd20;
    tick;
    start = 1'b0;
    wait_done(ok);
    d = ok ? done_c[db] : -1;
    vectors++;
    if (!ok || rd_a.size() - rb !== E || wr_a.size() - wb !== E) begin
      miscompares++;
      $display("FAIL b2b_run1_count got %0d/%0d want %0d",
               rd_a.size() - rb, wr_a.size() - wb, E);
    end
    for (int i = 0; i < E; i++) begin
      if (wb + i < wr_a.size()) begin
        vectors++;
        if (wr_a[wb+i] !== ex_a[i] || wr_d[wb+i] !== ex_d[i]) begin
          miscompares++;
          $display("FAIL b2b_run1_el%0d got %h@%h want %h@%h", i,
                   wr_d[wb+i], wr_a[wb+i], ex_d[i], ex_a[i]);
        end
      end
    end
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_run1_ovf got %b want 1", overflow);
    end
    build_model(8'd1, 5'd0, 5'd25);
    snap;
    start = 1'b1;
    escalar = 8'd1;
    src_base = 5'd0;
    dst_base = 5'd25;
    tick;
    @(posedge clk);
    #1;
    k2 = cyc;
    start = 1'b0;
    tick;
    vectors++;
    if (rd_a.size() <= rb || rd_c[rb] !== d + 2) begin
      miscompares++;
      $display("FAIL b2b_reaccept got %0d want %0d",
               (rd_a.size() > rb) ? rd_c[rb] - d : -1, 2);
    end
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_ovf_clear got %b want 0", overflow);
    end
    wait_done(ok);
    vectors++;
    if (!ok || done_c[db] !== k2 + 3 * E || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_run2_done got %0d ovf %b want %0d ovf 0",
               ok ? done_c[db] - k2 : -1, overflow, 3 * E);
    end
    for (int i = 0; i < E; i++) begin
      if (wb + i < wr_a.size()) begin
        vectors++;
        if (wr_a[wb+i] !== ex_a[i] || wr_d[wb+i] !== ex_d[i]) begin
          miscompares++;
          $display("FAIL b2b_run2_el%0d got %h@%h want %h@%h", i,
                   wr_d[wb+i], wr_a[wb+i], ex_d[i], ex_a[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int k;
    bit ok;
    for (int i = 0; i < MS; i++) load_data[i] = 8'($urandom);
    load_mem;
    launch(8'($urandom), 5'd0, 5'd25, k);
    repeat (31) tick;
    rst_n = 1'b0;
    tick;
    vectors++;
    if ({busy, done, overflow, mem_rd, mem_wr, mem_addr, mem_wdata} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_outputs got %b want 0",
               {busy, done, overflow, mem_rd, mem_wr, mem_addr, mem_wdata});
    end
    rst_n = 1'b1;
    repeat (100) tick;
    vectors++;
    if (wr_a.size() - wb !== 10 || done_c.size() !== db || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_abort got wr%0d done%0d busy%b want wr10 done0 busy0",
               wr_a.size() - wb, done_c.size() - db, busy);
    end
    launch(8'($urandom), 5'd0, 5'd25, k);
    wait_done(ok);
    vectors++;
    if (!ok || done_c[db] !== k + 3 * E || wr_a.size() - wb !== E) begin
      miscompares++;
      $display("FAIL rstmid_rerun got done%0d wr%0d want %0d/%0d",
               ok ? done_c[db] - k : -1, wr_a.size() - wb, 3 * E, E);
    end
    for (int i = 0; i < E; i++) begin
      if (wb + i < wr_a.size()) begin
        vectors++;
        if (wr_a[wb+i] !== ex_a[i] || wr_d[wb+i] !== ex_d[i]) begin
          miscompares++;
          $display("FAIL rstmid_el%0d got %h@%h want %h@%h", i,
                   wr_d[wb+i], wr_a[wb+i], ex_d[i], ex_a[i]);
        end
      end
    end
    vectors++;
    if (overflow !== ex_ovf) begin
      miscompares++;
      $display("FAIL rstmid_ovf got %b want %b", overflow, ex_ovf);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_random;
    test_neg_overflow;
    test_boundary;
    test_inplace;
    test_back_to_back;
    test_reset_mid;
    vectors++;
    if (both_n !== 0) begin
      miscompares++;
      $display("FAIL rd_wr_overlap got %0d want 0", both_n);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
